// File: rtl/c3lib_sync_pkg.sv
// -----------------------------------------------------------------------------
// c3lib_sync_pkg
// Shared constants and types for the c3lib level-signal synchronizer family.
//   - Legal parameter ranges, checked at elaboration by the top level.
//   - filt_act_e: the per-channel, per-cycle filter decision.
// -----------------------------------------------------------------------------
package c3lib_sync_pkg;

  localparam int WIDTH_MIN       = 1;
  localparam int WIDTH_MAX       = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILTER_CNT_MIN  = 1;
  localparam int FILTER_CNT_MAX  = 255;

  // What the glitch filter of one channel does on the coming clk edge.
  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,  // synchronized level matches output, or filter mode changing
    ACT_COUNT  = 2'd1,  // mismatch still young: keep counting
    ACT_ACCEPT = 2'd2,  // mismatch held long enough: take the new level
    ACT_BYPASS = 2'd3   // filter disabled: follow the synchronizer directly
  } filt_act_e;

endpackage : c3lib_sync_pkg

// File: rtl/c3lib_sync_deglitch_chan.sv
// -----------------------------------------------------------------------------
// c3lib_sync_deglitch_chan
// One channel: synchronizer chain, stability counter (glitch filter) and
// registered rise/fall edge pulses.
// Ports:
//   clk          in  1  sampling clock
//   rst_n        in  1  asynchronous active-low reset
//   i_data       in  1  asynchronous level input
//   i_filt_en    in  1  1: filter active, 0: follow synchronizer
//   i_filt_hold  in  1  filter mode is changing this cycle: clear, do not update
//   o_data       out 1  synchronized, filtered level
//   o_rise       out 1  one-cycle pulse the cycle after o_data goes 0->1
//   o_fall       out 1  one-cycle pulse the cycle after o_data goes 1->0
// -----------------------------------------------------------------------------
module c3lib_sync_deglitch_chan
  import c3lib_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_CNT  = 4,
  parameter int   CNT_W       = $clog2(FILTER_CNT + 1),
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_data,
  input  logic i_filt_en,
  input  logic i_filt_hold,
  output logic o_data,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

  logic             w_sync_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dout;
  logic             w_dout_nxt;
  logic             r_dout_d;
  logic             r_rise;
  logic             r_fall;
  filt_act_e        w_act;

  // Synchronizer: the hardened cell is kept intact by the implementation flow;
  // the behavioral model is used everywhere else.
`ifdef C3LIB_SYNC_TECH_CELL
  (* dont_touch = "true" *)
  c3lib_sync_tech_cell #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_data),
    .o_q   (w_sync_q)
  );
`else
  c3lib_sync_metastable_behav_gate #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_data),
    .o_q   (w_sync_q)
  );
`endif

  // Filter decision. The counter only advances while below CNT_LAST and is
  // cleared on acceptance, so it saturates by construction and cannot wrap.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    w_act      = ACT_CLEAR;
    w_cnt_nxt  = '0;
    w_dout_nxt = r_dout;

    if (i_filt_hold) begin
      w_act = ACT_CLEAR;
    end else if (!i_filt_en) begin
      w_act = ACT_BYPASS;
    end else if (w_sync_q == r_dout) begin
      w_act = ACT_CLEAR;
    end else if (r_cnt == CNT_LAST) begin
      w_act = ACT_ACCEPT;
    end else begin
      w_act = ACT_COUNT;
    end

    case (w_act)
      ACT_COUNT:  w_cnt_nxt  = r_cnt + CNT_W'(1);
      ACT_ACCEPT: w_dout_nxt = w_sync_q;
      ACT_BYPASS: w_dout_nxt = w_sync_q;
      default:    w_cnt_nxt  = '0;
    endcase
  end

  // Edge pulses compare data_out with its own delayed copy, so they appear the
  // cycle after the change. The delayed copy resets to RESET_VAL, so neither
  // reset assertion nor release produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_dout   <= RESET_VAL;
      r_dout_d <= RESET_VAL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_dout   <= w_dout_nxt;
      r_dout_d <= r_dout;
      r_rise   <= r_dout & ~r_dout_d;
      r_fall   <= ~r_dout & r_dout_d;
    end
  end

  assign o_data = r_dout;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : c3lib_sync_deglitch_chan

// File: rtl/c3lib_sync_metastable_behav_gate.sv
// -----------------------------------------------------------------------------
// c3lib_sync_metastable_behav_gate
// Behavioral model of a single-bit multi-flop synchronizer. Every flop resets
// to RESET_VAL so the chain comes out of reset already holding the strap's
// expected level.
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  asynchronous active-low reset
//   i_d    in  1  asynchronous input
//   o_q    out 1  input delayed by STAGES clk edges
// -----------------------------------------------------------------------------
module c3lib_sync_metastable_behav_gate #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // NOTE: every synchronizer flop is reset (to RESET_VAL, not zero) so that a
  // pad strapped to its default level never shows a transient after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, giving a true shift register.
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule : c3lib_sync_metastable_behav_gate

// File: rtl/c3lib_sync_deglitch_gate.sv
// -----------------------------------------------------------------------------
// c3lib_sync_deglitch_gate
// Multi-channel synchronizer for asynchronous level signals (straps, sideband
// status, pad inputs) with per-bit reset value, programmable depth, digital
// glitch filter and one-cycle rise/fall pulses. Channels are independent; no
// coherency is implied across bits of data_out.
// Ports:
//   clk       in  1      sampling clock
//   rst_n     in  1      asynchronous active-low reset
//   data_in   in  WIDTH  asynchronous inputs
//   filt_en   in  1      1: glitch filter active, 0: bypass (quasi-static)
//   data_out  out WIDTH  synchronized, filtered level
//   rise_pls  out WIDTH  1-cycle pulse after a data_out bit goes 0->1
//   fall_pls  out WIDTH  1-cycle pulse after a data_out bit goes 1->0
// -----------------------------------------------------------------------------
module c3lib_sync_deglitch_gate
  import c3lib_sync_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}},
  parameter int               FILTER_CNT  = 4,
  parameter int               CNT_W       = $clog2(FILTER_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             filt_en,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pls,
  output logic [WIDTH-1:0] fall_pls
);

  // Parameter range checks at elaboration.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_err_width
    $error("c3lib_sync_deglitch_gate: WIDTH=%0d out of range", WIDTH);
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_err_stages
    $error("c3lib_sync_deglitch_gate: SYNC_STAGES=%0d out of range", SYNC_STAGES);
  end
  if (FILTER_CNT < FILTER_CNT_MIN || FILTER_CNT > FILTER_CNT_MAX) begin : g_err_filter
    $error("c3lib_sync_deglitch_gate: FILTER_CNT=%0d out of range", FILTER_CNT);
  end
  if (CNT_W != $clog2(FILTER_CNT + 1)) begin : g_err_cntw
    $error("c3lib_sync_deglitch_gate: CNT_W must not be overridden");
  end

  // A change of filt_en holds every channel for that edge and clears its
  // counter, so switching modes mid-count neither updates data_out nor pulses;
  // a re-enabled filter then needs a full FILTER_CNT run of stable samples.
  logic r_filt_en_q;
  logic w_filt_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_en_q <= 1'b1;
    end else begin
      r_filt_en_q <= filt_en;
    end
  end

  assign w_filt_hold = filt_en ^ r_filt_en_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    c3lib_sync_deglitch_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_CNT  (FILTER_CNT),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL[gi])
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_data      (data_in[gi]),
      .i_filt_en   (filt_en),
      .i_filt_hold (w_filt_hold),
      .o_data      (data_out[gi]),
      .o_rise      (rise_pls[gi]),
      .o_fall      (fall_pls[gi])
    );
  end

endmodule : c3lib_sync_deglitch_gate

// File: tb/tb_c3lib_sync_deglitch_gate.sv
// -----------------------------------------------------------------------------
// tb_c3lib_sync_deglitch_gate
// Directed bench. Main instance: WIDTH=4, SYNC_STAGES=2, FILTER_CNT=4,
// RESET_VAL=4'b1010. Second instance: WIDTH=1, SYNC_STAGES=3, FILTER_CNT=1.
// Inputs change 1 ns after a rising edge; edge k is the k-th rising edge after
// the change, and outputs are sampled 1 ns after it.
// -----------------------------------------------------------------------------
module tb_c3lib_sync_deglitch_gate;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       filt_en;
  logic [3:0] data_out;
  logic [3:0] rise_pls;
  logic [3:0] fall_pls;

  logic [0:0] w_in;
  logic [0:0] w_out;
  logic [0:0] w_rise;
  logic [0:0] w_fall;

  int checks = 0;
  int errors = 0;

  c3lib_sync_deglitch_gate #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .RESET_VAL   (4'b1010),
    .FILTER_CNT  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .filt_en  (filt_en),
    .data_out (data_out),
    .rise_pls (rise_pls),
    .fall_pls (fall_pls)
  );

  c3lib_sync_deglitch_gate #(
    .WIDTH       (1),
    .SYNC_STAGES (3),
    .RESET_VAL   (1'b0),
    .FILTER_CNT  (1)
  ) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (w_in),
    .filt_en  (1'b1),
    .data_out (w_out),
    .rise_pls (w_rise),
    .fall_pls (w_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    data_in = 4'b1010;
    filt_en = 1'b1;
    w_in    = 1'b0;
    #12;
    checks++;
    if ({data_out, rise_pls, fall_pls} !== {4'b1010, 8'h00}) begin
      errors++;
      $display("FAIL reset_hold: out/rise/fall=%b/%b/%b expected 1010/0000/0000",
               data_out, rise_pls, fall_pls);
    end
    checks++;
    if ({w_out, w_rise, w_fall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold_w1: out/rise/fall=%b/%b/%b expected 0/0/0", w_out, w_rise, w_fall);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {4'b1010, 8'h00}) begin
        errors++;
        $display("FAIL reset_release k=%0d: out/rise/fall=%b/%b/%b expected 1010/0000/0000",
                 k, data_out, rise_pls, fall_pls);
      end
    end
  endtask

  task automatic test_clean_edge();
    logic [3:0] exp_out, exp_rise;
    data_in = 4'b1011;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_out  = (k >= 6) ? 4'b1011 : 4'b1010;
      exp_rise = (k == 7) ? 4'b0001 : 4'b0000;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {exp_out, exp_rise, 4'b0000}) begin
        errors++;
        $display("FAIL clean_edge k=%0d: out/rise/fall=%b/%b/%b expected %b/%b/0000",
                 k, data_out, rise_pls, fall_pls, exp_out, exp_rise);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_out, exp_rise, exp_fall;
    // Bit1 low for 3 cycles: shorter than FILTER_CNT, must be dropped.
    data_in = 4'b1001;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) data_in = 4'b1011;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {4'b1011, 8'h00}) begin
        errors++;
        $display("FAIL glitch_short k=%0d: out/rise/fall=%b/%b/%b expected 1011/0000/0000",
                 k, data_out, rise_pls, fall_pls);
      end
    end
    // Bit1 low for 4 cycles: accepted at edge 6, returns high at edge 10.
    data_in = 4'b1001;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) data_in = 4'b1011;
      exp_out  = (k >= 6 && k <= 9) ? 4'b1001 : 4'b1011;
      exp_fall = (k == 7)  ? 4'b0010 : 4'b0000;
      exp_rise = (k == 11) ? 4'b0010 : 4'b0000;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {exp_out, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL glitch_accept k=%0d: out/rise/fall=%b/%b/%b expected %b/%b/%b",
                 k, data_out, rise_pls, fall_pls, exp_out, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_bypass();
    logic [3:0] exp_out, exp_rise, exp_fall;
    filt_en = 1'b0;
    data_in = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_out  = (k >= 3) ? 4'b1111 : 4'b1011;
      exp_rise = (k == 4) ? 4'b0100 : 4'b0000;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {exp_out, exp_rise, 4'b0000}) begin
        errors++;
        $display("FAIL bypass_rise k=%0d: out/rise/fall=%b/%b/%b expected %b/%b/0000",
                 k, data_out, rise_pls, fall_pls, exp_out, exp_rise);
      end
    end
    data_in = 4'b1011;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_out  = (k >= 3) ? 4'b1011 : 4'b1111;
      exp_fall = (k == 4) ? 4'b0100 : 4'b0000;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {exp_out, 4'b0000, exp_fall}) begin
        errors++;
        $display("FAIL bypass_fall k=%0d: out/rise/fall=%b/%b/%b expected %b/0000/%b",
                 k, data_out, rise_pls, fall_pls, exp_out, exp_fall);
      end
    end
    // Re-enable, then drop filt_en for one cycle at cnt=2: counting restarts.
    filt_en = 1'b1;
    repeat (3) step();
    data_in = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) filt_en = 1'b0;
      if (k == 5) filt_en = 1'b1;
      exp_out  = (k >= 10) ? 4'b1111 : 4'b1011;
      exp_rise = (k == 11) ? 4'b0100 : 4'b0000;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {exp_out, exp_rise, 4'b0000}) begin
        errors++;
        $display("FAIL filt_toggle k=%0d: out/rise/fall=%b/%b/%b expected %b/%b/0000",
                 k, data_out, rise_pls, fall_pls, exp_out, exp_rise);
      end
    end
  endtask

  task automatic test_reset_mid();
    data_in = 4'b0111;
    repeat (4) step();
    checks++;
    if ({data_out, rise_pls, fall_pls} !== {4'b1111, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_pending: out/rise/fall=%b/%b/%b expected 1111/0000/0000",
               data_out, rise_pls, fall_pls);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, rise_pls, fall_pls} !== {4'b1010, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_async: out/rise/fall=%b/%b/%b expected 1010/0000/0000",
               data_out, rise_pls, fall_pls);
    end
    data_in = 4'b1010;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {4'b1010, 8'h00}) begin
        errors++;
        $display("FAIL reset_mid_release k=%0d: out/rise/fall=%b/%b/%b expected 1010/0000/0000",
                 k, data_out, rise_pls, fall_pls);
      end
    end
  endtask

  task automatic test_parallel();
    logic [3:0] exp_out, exp_rise, exp_fall;
    data_in = 4'b0101;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_out  = (k >= 6) ? 4'b0101 : 4'b1010;
      exp_rise = (k == 7) ? 4'b0101 : 4'b0000;
      exp_fall = (k == 7) ? 4'b1010 : 4'b0000;
      checks++;
      if ({data_out, rise_pls, fall_pls} !== {exp_out, exp_rise, exp_fall}) begin
        errors++;
        $display("FAIL parallel k=%0d: out/rise/fall=%b/%b/%b expected %b/%b/%b",
                 k, data_out, rise_pls, fall_pls, exp_out, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_sweep_w1();
    logic exp_out, exp_pls;
    // SYNC_STAGES=3, FILTER_CNT=1: latency 4 edges, pulse at edge 5.
    w_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_out = (k >= 4);
      exp_pls = (k == 5);
      checks++;
      if ({w_out, w_rise, w_fall} !== {exp_out, exp_pls, 1'b0}) begin
        errors++;
        $display("FAIL sweep_rise k=%0d: out/rise/fall=%b/%b/%b expected %b/%b/0",
                 k, w_out, w_rise, w_fall, exp_out, exp_pls);
      end
    end
    w_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_out = (k < 4);
      exp_pls = (k == 5);
      checks++;
      if ({w_out, w_rise, w_fall} !== {exp_out, 1'b0, exp_pls}) begin
        errors++;
        $display("FAIL sweep_fall k=%0d: out/rise/fall=%b/%b/%b expected %b/0/%b",
                 k, w_out, w_rise, w_fall, exp_out, exp_pls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch();
    test_bypass();
    test_reset_mid();
    test_parallel();
    test_sweep_w1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_c3lib_sync_deglitch_gate
